dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single-port data
//            memory. Each access takes IDLE -> ACCESS -> DONE.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_last;
    logic        r_id;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_any_req;
    logic        w_win;
    logic        w_grant;
    logic        w_access;
    logic        w_addr_err;
    logic [31:0] w_rdata;

    // On a tie the requester that was not granted last wins.
    assign w_any_req  = req0 | req1;
    assign w_win      = (req0 & req1) ? ~r_last : req1;
    assign w_addr_err = (r_addr[1:0] != 2'b00) || (r_addr >= ADDR_LIMIT);
    assign w_rdata    = (r_we || w_addr_err) ? 32'd0 : mem_rdata;

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_access = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next  = ACCESS;
                    w_grant = 1'b1;
                end
            end
            ACCESS: begin
                w_access = 1'b1;
                w_next   = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_gnt0    <= w_grant & ~w_win;
            r_gnt1    <= w_grant & w_win;
            r_rvalid0 <= w_access & ~r_id;
            r_rvalid1 <= w_access & r_id;
            r_err0    <= w_access & ~r_id & w_addr_err;
            r_err1    <= w_access & r_id & w_addr_err;
            if (w_grant) begin
                r_last  <= w_win;
                r_id    <= w_win;
                r_we    <= w_win ? we1 : we0;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
            end
            if (w_access) begin
                if (r_id) begin
                    r_rdata1 <= w_rdata;
                end else begin
                    r_rdata0 <= w_rdata;
                end
            end
        end
    end

    // Strobes come straight from state so an async reset kills them at once.
    assign mem_write = w_access & ~w_addr_err & r_we;
    assign mem_read  = w_access & ~w_addr_err & ~r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != IDLE);

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule

`default_nettype wire
